// File: rtl/species_filter.sv
// Debounces a stream of classifier results: a class is committed only after
// STABLE_N consecutive identical legal samples; per-class commit counters saturate.
module species_filter #(
  parameter int STABLE_N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  species_in,
  input  logic [31:0] score_in,
  output logic        out_valid,
  output logic [1:0]  species_out,
  output logic [31:0] score_out,
  output logic        changed,
  output logic        has_decision,
  output logic        err,
  output logic [7:0]  count0,
  output logic [7:0]  count1,
  output logic [7:0]  count2
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [3:0] LEN_MAX = 4'(STABLE_N);

  state_t     state, state_nx;
  logic [1:0] run_sp, run_sp_nx;
  logic [3:0] run_len, run_len_nx;
  logic       legal, illegal, match, hold_lock, commit;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

  always_comb begin
    state_nx   = state;
    run_sp_nx  = run_sp;
    run_len_nx = run_len;
    commit     = 1'b0;
    legal      = in_valid && (species_in != 2'd3);
    illegal    = in_valid && (species_in == 2'd3);
    match      = (state != IDLE) && (species_in == run_sp);
    // a locked run that keeps matching neither re-commits nor leaves LOCKED
    hold_lock  = (state == LOCKED) && match;
    if (illegal) begin
      state_nx   = IDLE;
      run_len_nx = 4'd0;
    end else if (legal) begin
      if (match) begin
        run_len_nx = (run_len == LEN_MAX) ? run_len : run_len + 4'd1;
      end else begin
        run_sp_nx  = species_in;
        run_len_nx = 4'd1;
      end
      if (!hold_lock) begin
        if (run_len_nx == LEN_MAX) begin
          commit   = 1'b1;
          state_nx = LOCKED;
        end else begin
          state_nx = TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_sp  <= 2'd0;
      run_len <= 4'd0;
    end else begin
      state   <= state_nx;
      run_sp  <= run_sp_nx;
      run_len <= run_len_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      changed      <= 1'b0;
      err          <= 1'b0;
      has_decision <= 1'b0;
      species_out  <= 2'd0;
      score_out    <= 32'd0;
      count0       <= 8'd0;
      count1       <= 8'd0;
      count2       <= 8'd0;
    end else begin
      out_valid <= commit;
      err       <= illegal;
      changed   <= commit && (!has_decision || (species_out != species_in));
      if (commit) begin
        species_out  <= species_in;
        score_out    <= score_in;
        has_decision <= 1'b1;
        case (species_in)
          2'd0:    count0 <= sat_inc(count0);
          2'd1:    count1 <= sat_inc(count1);
          default: count2 <= sat_inc(count2);
        endcase
      end
    end
  end

endmodule
